// File: rtl/lut_layer_sequencer.sv
// Time-multiplexed evaluator for one sparse LUT layer: one neuron per cycle through a shared
// truth-table read path, runtime-loadable select and truth tables, valid/ready on both sides.
module lut_layer_sequencer #(
  parameter int NUM_IN      = 8,
  parameter int NUM_NEURONS = 8,
  parameter int ACT_BITS    = 2,
  parameter int FANIN       = 3,
  parameter int SEL_W       = $clog2(NUM_IN),
  parameter int A           = FANIN * ACT_BITS,
  parameter int NW          = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [NUM_IN*ACT_BITS-1:0]      in_vec,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [NUM_NEURONS*ACT_BITS-1:0] out_vec,
  input  logic                            tt_we,
  input  logic [NW-1:0]                   tt_neuron,
  input  logic [A-1:0]                    tt_addr,
  input  logic [ACT_BITS-1:0]             tt_data,
  input  logic                            sel_we,
  input  logic [NW-1:0]                   sel_neuron,
  input  logic [FANIN*SEL_W-1:0]          sel_data,
  output logic                            busy,
  output logic                            cfg_err
);

  typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;

  localparam logic [NW:0] LAST = NUM_NEURONS[NW:0];
  localparam logic [NW:0] ONE  = 1;

  state_t               state;
  logic [NW:0]          cnt;
  logic [NW-1:0]        k;
  logic                 slot_act;
  logic [ACT_BITS-1:0]  vec_r   [NUM_IN];
  logic [ACT_BITS-1:0]  tt_mem  [NUM_NEURONS][2**A];
  logic [FANIN*SEL_W-1:0] sel_mem [NUM_NEURONS];
  logic [A-1:0]         addr;
  logic [ACT_BITS-1:0]  lut_q;
  logic                 tt_ok;
  logic                 sel_ok;

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  assign k        = cnt[NW-1:0];
  assign slot_act = (cnt < LAST);

  // Writes only land while idle and for an existing neuron; anything else is dropped.
  assign tt_ok  = tt_we  && (state == IDLE) && ({1'b0, tt_neuron}  < LAST);
  assign sel_ok = sel_we && (state == IDLE) && ({1'b0, sel_neuron} < LAST);

  always_comb begin
    addr = '0;
    for (int j = 0; j < FANIN; j++) begin
      addr[j*ACT_BITS +: ACT_BITS] = vec_r[sel_mem[k][j*SEL_W +: SEL_W]];
    end
  end

  assign lut_q = tt_mem[k][addr];

  // Table storage is deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (tt_ok)  tt_mem[tt_neuron][tt_addr] <= tt_data;
      if (sel_ok) sel_mem[sel_neuron]        <= sel_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_vec   <= '0;
      cfg_err   <= 1'b0;
      cnt       <= '0;
    end else begin
      cfg_err <= (tt_we && !tt_ok) || (sel_we && !sel_ok);
      case (state)
        IDLE: begin
          if (in_valid) begin
            for (int i = 0; i < NUM_IN; i++) begin
              vec_r[i] <= in_vec[i*ACT_BITS +: ACT_BITS];
            end
            cnt   <= '0;
            state <= EVAL;
          end
        end
        EVAL: begin
          // Counter runs one past the last neuron; that closing cycle raises out_valid.
          if (slot_act) begin
            out_vec[k*ACT_BITS +: ACT_BITS] <= lut_q;
            cnt <= cnt + ONE;
          end else begin
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lut_layer_sequencer.sv
// Directed-plus-random bench for lut_layer_sequencer against a table-lookup reference model.
module tb_lut_layer_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_vec;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_vec;
  logic        tt_we;
  logic [2:0]  tt_neuron;
  logic [5:0]  tt_addr;
  logic [1:0]  tt_data;
  logic        sel_we;
  logic [2:0]  sel_neuron;
  logic [8:0]  sel_data;
  logic        busy;
  logic        cfg_err;

  int checks = 0;
  int errors = 0;
  int lat;

  logic [1:0] tt_m  [8][64];
  int         sel_m [8][3];

  lut_layer_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
    .out_valid(out_valid), .out_ready(out_ready), .out_vec(out_vec),
    .tt_we(tt_we), .tt_neuron(tt_neuron), .tt_addr(tt_addr), .tt_data(tt_data),
    .sel_we(sel_we), .sel_neuron(sel_neuron), .sel_data(sel_data),
    .busy(busy), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] addr_of(input int n, input logic [15:0] v);
    logic [5:0] a = 0;
    for (int j = 0; j < 3; j++) a = a | (6'(v[sel_m[n][j]*2 +: 2]) << (2*j));
    return a;
  endfunction

  function automatic logic [15:0] model(input logic [15:0] v);
    logic [15:0] r = 0;
    for (int n = 0; n < 8; n++) r = r | (16'(tt_m[n][addr_of(n, v)]) << (2*n));
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_tt(input int n, input int a, input logic [1:0] d);
    tt_we = 1'b1; tt_neuron = 3'(n); tt_addr = 6'(a); tt_data = d;
    step();
    tt_we = 1'b0;
    tt_m[n][a] = d;
  endtask

  task automatic wr_sel(input int n, input int s0, input int s1, input int s2);
    sel_we = 1'b1; sel_neuron = 3'(n);
    sel_data = {3'(s2), 3'(s1), 3'(s0)};
    step();
    sel_we = 1'b0;
    sel_m[n][0] = s0; sel_m[n][1] = s1; sel_m[n][2] = s2;
  endtask

  task automatic start_vec(input logic [15:0] v);
    in_vec = v; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    lat = 0;
  endtask

  task automatic finish_vec(input string tag, input logic [15:0] exp);
    while (!out_valid && lat < 40) begin
      step();
      lat++;
    end
    chk({tag, "_latency"}, lat, 9);
    chk({tag, "_out_vec"}, out_vec, exp);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_back_idle"}, {out_valid, in_ready, busy}, 3'b010);
  endtask

  task automatic run_vec(input string tag, input logic [15:0] v);
    start_vec(v);
    finish_vec(tag, model(v));
  endtask

  initial begin
    logic [15:0] v, exp;
    logic [5:0]  a;
    rst_n = 1'b0; in_valid = 1'b0; in_vec = '0; out_ready = 1'b0;
    tt_we = 1'b0; tt_neuron = '0; tt_addr = '0; tt_data = '0;
    sel_we = 1'b0; sel_neuron = '0; sel_data = '0;
    repeat (3) step();
    rst_n = 1'b1;
    chk("rst_state", {in_ready, busy, out_valid, cfg_err}, 4'b1000);
    chk("rst_out_vec", out_vec, 16'h0);
    step();
    chk("post_rst_state", {in_ready, busy, out_valid}, 3'b100);

    // Random tables, then random vectors.
    for (int n = 0; n < 8; n++) begin
      wr_sel(n, $urandom_range(7), $urandom_range(7), $urandom_range(7));
      for (int i = 0; i < 64; i++) wr_tt(n, i, 2'($urandom));
    end
    chk("cfg_err_idle_writes", cfg_err, 1'b0);
    for (int t = 0; t < 4; t++) run_vec("rand", 16'($urandom));

    // A write strobed during reset must not land.
    v = 16'($urandom);
    a = addr_of(0, v);
    rst_n = 1'b0;
    tt_we = 1'b1; tt_neuron = 3'd0; tt_addr = a; tt_data = ~tt_m[0][a];
    step();
    step();
    tt_we = 1'b0; rst_n = 1'b1;
    run_vec("tt_we_in_reset", v);

    // Directed single-entry table on neuron 0.
    wr_sel(0, 0, 1, 2);
    for (int i = 0; i < 64; i++) wr_tt(0, i, (i == 12) ? 2'b01 : 2'b00);
    start_vec(16'h000C);
    finish_vec("addr12", model(16'h000C));
    chk("addr12_slot0", out_vec[1:0], 2'b01);
    start_vec(16'h0001);
    finish_vec("addr1", model(16'h0001));
    chk("addr1_slot0", out_vec[1:0], 2'b00);

    // Identity tables: each neuron forwards its own activation.
    for (int n = 0; n < 8; n++) begin
      wr_sel(n, n, 0, 0);
      for (int i = 0; i < 64; i++) wr_tt(n, i, 2'(i));
    end
    start_vec(16'hE4A1);
    finish_vec("identity", 16'hE4A1);

    // Backpressure: hold DONE for 20 cycles with a competing input offered.
    v = 16'($urandom);
    exp = model(v);
    start_vec(v);
    while (!out_valid && lat < 40) begin
      step();
      lat++;
    end
    chk("bp_latency", lat, 9);
    in_valid = 1'b1; in_vec = ~v;
    for (int c = 0; c < 20; c++) begin
      chk("bp_hold", {out_valid, in_ready, busy, out_vec}, {3'b101, exp});
      step();
    end
    sel_we = 1'b1; sel_neuron = 3'd1; sel_data = 9'h1FF;
    step();
    sel_we = 1'b0;
    chk("bp_sel_drop_err", cfg_err, 1'b1);
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp_release", {out_valid, in_ready, busy}, 3'b010);
    step();
    chk("bp_second_not_taken", {busy, cfg_err}, 2'b00);
    run_vec("after_sel_drop", 16'($urandom));

    // Truth-table write during evaluation is dropped.
    v = 16'($urandom);
    a = addr_of(7, v);
    start_vec(v);
    step();
    step();
    lat = 2;
    tt_we = 1'b1; tt_neuron = 3'd7; tt_addr = a; tt_data = ~tt_m[7][a];
    step();
    lat++;
    tt_we = 1'b0;
    chk("eval_write_err", cfg_err, 1'b1);
    step();
    lat++;
    chk("eval_write_err_pulse", cfg_err, 1'b0);
    finish_vec("eval_write", model(v));

    // Write coincident with the accepting handshake is seen by that pass.
    v = 16'($urandom);
    a = addr_of(2, v);
    tt_we = 1'b1; tt_neuron = 3'd2; tt_addr = a; tt_data = ~tt_m[2][a];
    tt_m[2][a] = ~tt_m[2][a];
    start_vec(v);
    tt_we = 1'b0;
    chk("hs_write_no_err", cfg_err, 1'b0);
    finish_vec("hs_write", model(v));

    // Reset during evaluation aborts the pass; tables survive.
    start_vec(16'($urandom));
    repeat (3) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("abort_idle", {in_ready, busy, out_valid}, 3'b100);
    for (int c = 0; c < 12; c++) begin
      if (out_valid) chk("abort_no_valid", out_valid, 1'b0);
      step();
    end
    chk("abort_still_idle", {in_ready, out_valid}, 2'b10);
    run_vec("after_abort", 16'($urandom));
    run_vec("after_abort2", 16'($urandom));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
